// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning (sync/debounce/edge detect),
// RUN/PAUSED/ADJUST state machine and the count/adjust/clear/blank qualifiers.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic tick_blink,
    input  logic btn_pause,
    input  logic btn_rst,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic count_en,
    output logic adj_en,
    output logic adj_sel,
    output logic clr,
    output logic blank_min,
    output logic blank_sec,
    output logic running,
    output logic adjusting
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_PAUSED = 2'd0,
        S_RUN    = 2'd1,
        S_ADJUST = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [1:0] press;
    logic       phase;

    // Bit order: 0 = pause button, 1 = clear button, 2 = adjust switch, 3 = select switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw_sel, sw_adj, btn_rst, btn_pause};
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          level;
        logic          pulse;

        // Level follows the synchronized input only after DEBOUNCE_CYCLES differing samples.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (sync2[b] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt   <= '0;
                    level <= sync2[b];
                    pulse <= sync2[b];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press[b] = pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_PAUSED;
        end else begin
            state <= state_next;
        end
    end

    // The adjust switch wins over a pause press arriving in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_PAUSED: begin
                if (sync2[2])      state_next = S_ADJUST;
                else if (press[0]) state_next = S_RUN;
            end
            S_RUN: begin
                if (sync2[2])      state_next = S_ADJUST;
                else if (press[0]) state_next = S_PAUSED;
            end
            S_ADJUST: begin
                if (!sync2[2])     state_next = S_PAUSED;
            end
            default: state_next = S_PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr      <= 1'b1;
            count_en <= 1'b0;
            adj_en   <= 1'b0;
            adj_sel  <= 1'b0;
            phase    <= 1'b0;
        end else begin
            clr      <= press[1];
            count_en <= tick_1hz && (state == S_RUN);
            adj_en   <= tick_2hz && (state == S_ADJUST);
            adj_sel  <= sync2[3];
            phase    <= (state == S_ADJUST) ? (phase ^ tick_blink) : 1'b0;
        end
    end

    assign running   = (state == S_RUN);
    assign adjusting = (state == S_ADJUST);
    // Gated by the current state so a phase left over from ADJUST never blanks.
    assign blank_min = adjusting & phase & adj_sel;
    assign blank_sec = adjusting & phase & ~adj_sel;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: reset/run table, directed corner sequences and a
// randomized run checked every cycle against a history-based reference model.
module tb_stopwatch_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset, tick_1hz, tick_2hz, tick_blink, btn_pause, btn_rst, sw_adj, sw_sel;
    logic count_en, adj_en, adj_sel, clr, blank_min, blank_sec, running, adjusting;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_blink(tick_blink), .btn_pause(btn_pause), .btn_rst(btn_rst),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .count_en(count_en), .adj_en(adj_en),
        .adj_sel(adj_sel), .clr(clr), .blank_min(blank_min), .blank_sec(blank_sec),
        .running(running), .adjusting(adjusting)
    );

    // Reference model: mode 0 = paused, 1 = run, 2 = adjust.
    int  m_mode;
    bit  raw_ago1[4];   // raw input seen at the previous edge
    bit  raw_ago2[4];   // raw input seen two edges ago
    bit  m_level[2];
    int  m_stable[2];
    bit  m_press[2];
    bit  m_phase;
    bit  e_count_en, e_adj_en, e_adj_sel, e_clr, e_blank_min, e_blank_sec;

    task automatic model_edge();
        bit raw[4];
        bit seen[4];
        bit old_press[2];
        raw = '{btn_pause, btn_rst, sw_adj, sw_sel};
        if (reset) begin
            m_mode = 0;
            for (int i = 0; i < 4; i++) begin raw_ago1[i] = 0; raw_ago2[i] = 0; end
            for (int b = 0; b < 2; b++) begin m_level[b] = 0; m_stable[b] = 0; m_press[b] = 0; end
            m_phase = 0;
            e_clr = 1; e_count_en = 0; e_adj_en = 0; e_adj_sel = 0;
            e_blank_min = 0; e_blank_sec = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            seen[i]     = raw_ago2[i];
            raw_ago2[i] = raw_ago1[i];
            raw_ago1[i] = raw[i];
        end
        old_press = m_press;
        e_count_en = tick_1hz && (m_mode == 1);
        e_adj_en   = tick_2hz && (m_mode == 2);
        e_clr      = old_press[1];
        e_adj_sel  = seen[3];
        if (m_mode == 2) m_phase = m_phase ^ tick_blink;
        else             m_phase = 0;
        if (m_mode != 2 && seen[2])      m_mode = 2;
        else if (m_mode == 2 && !seen[2]) m_mode = 0;
        else if (m_mode != 2 && old_press[0]) m_mode = 1 - m_mode;
        for (int b = 0; b < 2; b++) begin
            m_press[b] = 0;
            if (seen[b] != m_level[b]) begin
                m_stable[b]++;
                if (m_stable[b] == D) begin
                    m_level[b]  = seen[b];
                    m_stable[b] = 0;
                    m_press[b]  = seen[b];
                end
            end else begin
                m_stable[b] = 0;
            end
        end
        e_blank_min = (m_mode == 2) && m_phase && e_adj_sel;
        e_blank_sec = (m_mode == 2) && m_phase && !e_adj_sel;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("m_count_en", count_en, e_count_en);
        check("m_adj_en", adj_en, e_adj_en);
        check("m_adj_sel", adj_sel, e_adj_sel);
        check("m_clr", clr, e_clr);
        check("m_blank_min", blank_min, e_blank_min);
        check("m_blank_sec", blank_sec, e_blank_sec);
        check("m_running", running, m_mode == 1);
        check("m_adjusting", adjusting, m_mode == 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        logic rst, pause, clrb, t1;
        logic e_clr, e_run, e_cen;
    } vec_t;

    vec_t tbl[18];
    int   nclr;

    initial begin
        reset = 1; tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
        btn_pause = 0; btn_rst = 0; sw_adj = 0; sw_sel = 0;

        tbl[0]  = '{1,0,0,0, 1,0,0};
        tbl[1]  = '{1,0,0,0, 1,0,0};
        tbl[2]  = '{1,0,0,0, 1,0,0};
        tbl[3]  = '{0,0,0,0, 0,0,0};
        tbl[4]  = '{0,1,0,0, 0,0,0};
        tbl[5]  = '{0,1,0,0, 0,0,0};
        tbl[6]  = '{0,1,0,0, 0,0,0};
        tbl[7]  = '{0,1,0,0, 0,0,0};
        tbl[8]  = '{0,1,0,0, 0,0,0};
        tbl[9]  = '{0,1,0,0, 0,0,0};
        tbl[10] = '{0,1,0,0, 0,1,0};
        tbl[11] = '{0,1,0,0, 0,1,0};
        tbl[12] = '{0,1,0,0, 0,1,0};
        tbl[13] = '{0,1,0,0, 0,1,0};
        tbl[14] = '{0,0,0,1, 0,1,1};
        tbl[15] = '{0,0,0,0, 0,1,0};
        tbl[16] = '{0,0,0,1, 0,1,1};
        tbl[17] = '{0,0,0,0, 0,1,0};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; btn_pause = tbl[i].pause;
            btn_rst = tbl[i].clrb; tick_1hz = tbl[i].t1;
            cycle();
            check("tbl_clr", clr, tbl[i].e_clr);
            check("tbl_running", running, tbl[i].e_run);
            check("tbl_count_en", count_en, tbl[i].e_cen);
            check("tbl_adjusting", adjusting, 1'b0);
        end
        tick_1hz = 0;

        // Remaining three of five ticks, then settle the released button.
        for (int k = 0; k < 3; k++) begin
            tick_1hz = 1; cycle(); tick_1hz = 0;
            check("tick_count_en", count_en, 1'b1);
            cycle();
            check("tick_gap", count_en, 1'b0);
        end
        idle(6);

        // Second press stops the watch at the same latency.
        btn_pause = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("pause2_running", running, i < 6);
        end
        btn_pause = 0;
        idle(8);
        for (int k = 0; k < 2; k++) begin
            tick_1hz = 1; cycle(); tick_1hz = 0;
            check("paused_no_count", count_en, 1'b0);
        end

        // Bouncing button never qualifies.
        for (int i = 0; i < 20; i++) begin
            btn_pause = ((i / 2) % 2 == 0);
            cycle();
            check("bounce_running", running, 1'b0);
        end
        btn_pause = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bounce_settle", running, 1'b0);
        end

        btn_pause = 1; idle(10); btn_pause = 0; idle(8);
        check("rerun_running", running, 1'b1);

        // Adjust minutes with blinking.
        sw_adj = 1; sw_sel = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("adj_enter", adjusting, i == 2);
        end
        tick_1hz = 1; cycle(); tick_1hz = 0;
        check("adj_no_count", count_en, 1'b0);
        tick_2hz = 1; cycle(); tick_2hz = 0;
        check("adj_en_pulse", adj_en, 1'b1);
        check("adj_sel_min", adj_sel, 1'b1);
        cycle();
        check("adj_en_gap", adj_en, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick_blink = 1; cycle(); tick_blink = 0;
            check("blink_min", blank_min, (k % 2) == 0);
            check("blink_sec", blank_sec, 1'b0);
            cycle();
            check("blink_hold", blank_min, (k % 2) == 0);
        end
        tick_blink = 1; cycle(); tick_blink = 0;
        check("blink_on_exit", blank_min, 1'b1);
        sw_adj = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("adj_leave", adjusting, i < 2);
        end
        check("exit_blank_min", blank_min, 1'b0);
        check("exit_blank_sec", blank_sec, 1'b0);
        check("exit_paused", running, 1'b0);
        idle(3);

        // Clear and pause pressed together from PAUSED.
        nclr = 0;
        btn_pause = 1; btn_rst = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (clr) nclr++;
        end
        btn_pause = 0; btn_rst = 0;
        check("sim_one_clr", nclr == 1, 1'b1);
        check("sim_running", running, 1'b1);
        idle(8);

        // Clear press coinciding with a counting tick.
        btn_rst = 1;
        for (int i = 0; i < 7; i++) begin
            tick_1hz = (i == 6);
            cycle();
        end
        tick_1hz = 0; btn_rst = 0;
        check("clr_tick_clr", clr, 1'b1);
        check("clr_tick_count", count_en, 1'b1);
        check("clr_tick_state", running, 1'b1);
        idle(8);

        // Reset during ADJUST with a partially debounced press.
        sw_adj = 1; idle(4);
        check("pre_reset_adj", adjusting, 1'b1);
        btn_pause = 1; idle(4);
        reset = 1; sw_adj = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("mid_reset_clr", clr, 1'b1);
            check("mid_reset_adj", adjusting, 1'b0);
        end
        reset = 0;
        idle(2);
        btn_pause = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("post_reset_paused", running, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            tick_1hz   = ($urandom_range(0, 5) == 0);
            tick_2hz   = ($urandom_range(0, 5) == 0);
            tick_blink = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 7) == 0) btn_rst = ~btn_rst;
            if ($urandom_range(0, 79) == 0) sw_adj = ~sw_adj;
            if ($urandom_range(0, 29) == 0) sw_sel = ~sw_sel;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch minutes/seconds counting datapath and the seven-segment display. It conditions the raw board inputs: it synchronizes the switches, and it synchronizes, debounces and edge-detects the buttons. It runs a RUN/PAUSED/ADJUST state machine and emits the count, adjust, clear and blanking qualifiers. These qualifiers gate the counter's 1 Hz tick and make the selected field blink during adjustment. It sits between the board I/O and the counter/display pair.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a debounced button level changes. Must be ≥ 1. Use 4 in simulation and a large board value at integration.
- clk  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse once per second (counting rate)
- tick_2hz  in  1  one-cycle pulse twice per second (adjust rate)
- tick_blink  in  1  one-cycle pulse that toggles the blink phase
- btn_pause  in  1  raw pause/resume button, asynchronous
- btn_rst  in  1  raw clear button, asynchronous
- sw_adj  in  1  raw adjust-mode switch, asynchronous
- sw_sel  in  1  raw field select, asynchronous; 0 = seconds, 1 = minutes
- count_en  out  1  one-cycle pulse: advance the counter by one second
- adj_en  out  1  one-cycle pulse: increment the selected field
- adj_sel  out  1  registered, synchronized copy of sw_sel
- clr  out  1  clear the counter to 00:00
- blank_min  out  1  blank the minute digits
- blank_sec  out  1  blank the second digits
- running  out  1  state == RUN
- adjusting  out  1  state == ADJUST

## Operation
- Synchronization: every raw input passes through a 2-flop synchronizer before use.
- Debounce, per button:
  - Each button has a counter that increments while the synchronized level differs from the debounced level, and zeroes whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter zeroes.
  - A press pulse is high for exactly one cycle, in the cycle the debounced level first reads 1.
  - Releasing a button produces no pulse.
- States: RUN, PAUSED, ADJUST. The reset state is PAUSED.
  - In PAUSED or RUN, synchronized sw_adj = 1 moves to ADJUST.
  - In RUN, a pause press moves to PAUSED.
  - In PAUSED, a pause press moves to RUN.
  - In ADJUST, synchronized sw_adj = 0 moves to PAUSED. Pause presses are ignored in ADJUST.
  - sw_adj has priority over a pause press in the same cycle.
- Clear:
  - clr is high for one cycle, the cycle after a clear press, in any state. The state is unchanged.
  - clr is held high for every cycle that reset is high.
- count_en is registered: it is high the cycle after tick_1hz was high while the state was RUN.
- adj_en is registered: it is high the cycle after tick_2hz was high while the state was ADJUST.
- Blink:
  - The blink phase flop toggles on each tick_blink. It is held at 0 outside ADJUST.
  - In ADJUST: blank_sec = phase & ~adj_sel and blank_min = phase & adj_sel.
  - Outside ADJUST, both blank outputs are 0.
- Simultaneous events:
  - A clear press and a pause press in the same cycle both take effect: clr pulses and the state toggles.
  - A clear press and a tick in the same cycle: clr and count_en/adj_en are both asserted. The counter gives clr priority.
  - Leaving RUN in the same cycle as tick_1hz: that tick is still honored, because the qualifying state is sampled in the tick's cycle.

## Timing
- Reset values, held for every cycle reset is high:
  - clr = 1.
  - All other outputs = 0. This matches state PAUSED: running = 0, adjusting = 0.
  - Synchronizers, debounced levels, debounce counters and blink phase are all 0.
- Reset mid-debounce discards the partial count. Reset mid-ADJUST returns to PAUSED.
- Button latency: raw rises and stays high before edge 0. The synchronized level is 1 after edge 1. The press pulse is high in the cycle after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles after the raw rise.
- Press to effect:
  - Clear: clr is high one cycle after the press pulse.
  - Pause: the state, and the running output, change at the edge that ends the press-pulse cycle.
- Glitches: any raw button glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- Switch latency: 2 cycles through the synchronizer, then 1 cycle to the state register or the adj_sel register.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Reset: assert reset for 3 cycles → clr = 1 throughout, all other outputs 0. Release → clr = 0 and state is PAUSED.
- Run/pause, DEBOUNCE_CYCLES = 4:
  - Hold btn_pause high for 10 cycles → running = 1 exactly 7 cycles after the rise. Exactly one transition.
  - Then apply 5 tick_1hz pulses → 5 count_en pulses, each 1 cycle after its tick.
  - A second press → running = 0, and later ticks give no count_en.
- Bounce: toggle btn_pause every 2 cycles for 20 cycles, then hold it low → no press and running unchanged.
- Adjust and blink:
  - From RUN, set sw_adj = 1 and sw_sel = 1 → adjusting = 1 after 3 cycles, and count_en is suppressed.
  - Apply tick_2hz → adj_en pulses and adj_sel = 1.
  - Apply 4 tick_blink pulses → blank_min toggles 1,0,1,0 while blank_sec stays 0.
  - Clear sw_adj → PAUSED, and both blank outputs are 0.
- Simultaneous events:
  - Press btn_rst and btn_pause in the same cycle while in PAUSED → one clr pulse, and running = 1.
  - Apply tick_1hz in the same cycle as the clear press → count_en and clr both observed.
- Reset mid-operation: assert reset during ADJUST and mid-debounce → PAUSED, and no press pulse after release even though btn_pause was held fewer than DEBOUNCE_CYCLES cycles after release.
